sudoku_pipe_sched: RTL and testbench

Parametrised recirculating-pipeline scheduler for the sudoku solver. It owns a ring of `NUM_PIPE_STGS` slots around an external constraint-propagation datapath. It admits puzzles with a valid/ready handshake and recirculates each puzzle until it is solved, stuck, contradictory or out of iterations. It then retires the puzzle through a one-entry output register with a status code and pass count. Unlike the previous fixed 9x9, fixed 6-stage core, it has no priming phase, supports backpressure, and has a configurable grid size, depth and iteration limit.

---
 rtl/sudoku_pipe_sched.sv | 126 ++++++++++++
 tb/tb_sudoku_pipe_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sudoku_pipe_sched.sv
// Recirculating ring scheduler for the sudoku solver: admits puzzles, loops them
// through the external propagation datapath, and retires them via a one-entry output register.
module sudoku_pipe_sched #(
   parameter int N             = 9,
   parameter int CELL_W        = 4,
   parameter int NUM_PIPE_STGS = 6,
   parameter int MAX_ITER      = 32,
   parameter int ITER_W        = 6,
   localparam int DATA_W       = N*N*CELL_W,
   localparam int CNT_W        = $clog2(NUM_PIPE_STGS+1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              go,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [DATA_W-1:0] dp_data_o,
   output logic              dp_valid_o,
   input  logic [DATA_W-1:0] dp_data_i,
   input  logic              dp_contra_i,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_status,
   output logic [ITER_W-1:0] out_iters,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  slots_used
);

   localparam int PTR_W = $clog2(NUM_PIPE_STGS);
   localparam int NCELL = N*N;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_PIPE_STGS-1);
   localparam logic [ITER_W:0]  ITER_MAX = (ITER_W+1)'(MAX_ITER);
   localparam logic [1:0] ST_SOLVED = 2'd0;
   localparam logic [1:0] ST_STALL  = 2'd1;
   localparam logic [1:0] ST_CONTRA = 2'd2;
   localparam logic [1:0] ST_LIMIT  = 2'd3;

   logic [NUM_PIPE_STGS-1:0]             occ;
   logic [NUM_PIPE_STGS-1:0][ITER_W-1:0] iter;
   logic [NUM_PIPE_STGS-1:0][DATA_W-1:0] sent;
   logic [PTR_W-1:0]                     ptr;

   logic              head_occ, solved, stalled, limit, done;
   logic              out_free, retire, issue_new;
   logic [ITER_W:0]   iter_inc, iter_sat;
   logic [1:0]        status;

   always_comb begin
      solved = 1'b1;
      for (int c = 0; c < NCELL; c++)
         if (dp_data_i[c*CELL_W +: CELL_W] == '0) solved = 1'b0;
   end

   // iter_inc is one bit wider so the saturation compare cannot wrap
   always_comb begin
      head_occ = occ[ptr];
      iter_inc = {1'b0, iter[ptr]} + 1'b1;
      iter_sat = (iter_inc > ITER_MAX) ? ITER_MAX : iter_inc;
      stalled  = (dp_data_i == sent[ptr]);
      limit    = (iter_inc >= ITER_MAX);
      done     = dp_contra_i | solved | stalled | limit;
      if (dp_contra_i)  status = ST_CONTRA;
      else if (solved)  status = ST_SOLVED;
      else if (stalled) status = ST_STALL;
      else              status = ST_LIMIT;
   end

   assign out_free  = !out_valid | out_ready;
   assign retire    = go & head_occ & done & out_free;
   assign in_ready  = rst_n & go & (!head_occ | (done & out_free));
   assign issue_new = in_ready & in_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ        <= '0;
         iter       <= '0;
         sent       <= '0;
         ptr        <= '0;
         dp_valid_o <= 1'b0;
         dp_data_o  <= '0;
         slots_used <= '0;
      end else if (go) begin
         ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
         if (head_occ && !retire) begin
            // not done, or done but blocked by the output: take another pass
            dp_data_o    <= dp_data_i;
            dp_valid_o   <= 1'b1;
            iter[ptr]    <= iter_sat[ITER_W-1:0];
            sent[ptr]    <= dp_data_i;
         end else if (in_valid) begin
            dp_data_o    <= in_data;
            dp_valid_o   <= 1'b1;
            occ[ptr]     <= 1'b1;
            iter[ptr]    <= '0;
            sent[ptr]    <= in_data;
         end else begin
            dp_valid_o   <= 1'b0;
            occ[ptr]     <= 1'b0;
         end
         case ({issue_new, retire})
            2'b10:   slots_used <= slots_used + 1'b1;
            2'b01:   slots_used <= slots_used - 1'b1;
            default: ;
         endcase
      end
   end

   // output handshake runs regardless of go
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_status <= '0;
         out_iters  <= '0;
      end else if (retire) begin
         out_valid  <= 1'b1;
         out_data   <= dp_data_i;
         out_status <= status;
         out_iters  <= iter_sat[ITER_W-1:0];
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sudoku_pipe_sched.sv
// Directed bench for sudoku_pipe_sched: 4x4 grid, 6-slot ring, MAX_ITER=4,
// with a go-qualified behavioural datapath (identity or bit-0 toggle).
module tb_sudoku_pipe_sched;
   localparam int N = 4, CELL_W = 4, STG = 6, MAXI = 4, IW = 3;
   localparam int DW = N*N*CELL_W, CW = 3;
   localparam logic [DW-1:0] P_SOL = 64'h1234_4321_2143_3412;
   localparam logic [DW-1:0] P_ZER = 64'h0234_4321_2143_3412;

   logic clk = 1'b0;
   logic rst_n, go, in_valid, in_ready, dp_valid_o, dp_contra_i;
   logic out_valid, out_ready;
   logic [DW-1:0] in_data, dp_data_o, dp_data_i, out_data;
   logic [1:0]    out_status;
   logic [IW-1:0] out_iters;
   logic [CW-1:0] slots_used;

   int tests = 0, fails = 0;

   sudoku_pipe_sched #(.N(N), .CELL_W(CELL_W), .NUM_PIPE_STGS(STG), .MAX_ITER(MAXI), .ITER_W(IW)) dut (
      .clk(clk), .rst_n(rst_n), .go(go), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .dp_data_o(dp_data_o), .dp_valid_o(dp_valid_o),
      .dp_data_i(dp_data_i), .dp_contra_i(dp_contra_i), .out_valid(out_valid),
      .out_data(out_data), .out_status(out_status), .out_iters(out_iters),
      .out_ready(out_ready), .slots_used(slots_used)
   );

   always #5 clk = ~clk;

   // datapath model: STG-1 go-qualified stages after dp_data_o
   logic [DW-1:0] dpipe [STG-1];
   logic          cpipe [STG-1];
   logic          toggle, contra;
   always @(posedge clk) begin
      if (go) begin
         dpipe[0] <= toggle ? (dp_data_o ^ 64'h1) : dp_data_o;
         cpipe[0] <= contra;
         for (int i = 1; i < STG-1; i++) begin
            dpipe[i] <= dpipe[i-1];
            cpipe[i] <= cpipe[i-1];
         end
      end
   end
   assign dp_data_i   = dpipe[STG-2];
   assign dp_contra_i = cpipe[STG-2];

   typedef struct {
      logic [DW-1:0] data;
      logic [1:0]    st;
      logic [IW-1:0] it;
   } out_t;
   out_t mq[$];
   logic mon_en = 1'b0;
   always @(negedge clk)
      if (mon_en && rst_n && out_valid && out_ready)
         mq.push_back('{out_data, out_status, out_iters});

   typedef struct {
      logic [DW-1:0] data;
      logic          tog;
      logic          con;
      logic [1:0]    st;
      logic [IW-1:0] it;
      int            lat;
      logic [DW-1:0] od;
   } vec_t;
   vec_t vt[6];
   out_t ex[7];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; go = 1'b0; in_valid = 1'b0; in_data = '0;
      out_ready = 1'b0; toggle = 1'b0; contra = 1'b0;
      step(); step();
      rst_n = 1'b1;
   endtask

   task automatic wait_out(input int budget, output int lat);
      lat = 0;
      while (!out_valid && lat < budget) begin
         step();
         lat++;
      end
      if (!out_valid) begin
         tests++; fails++;
         $display("FAIL wait_out: out_valid not seen within %0d cycles", budget);
      end
   endtask

   function automatic logic [DW-1:0] pk(input int k);
      return (P_ZER & ~64'hF) | 64'(k+1);
   endfunction

   int lat;

   initial begin
      vt[0] = '{P_SOL, 1'b0, 1'b0, 2'd0, 3'd1, 6,  P_SOL};
      vt[1] = '{P_ZER, 1'b0, 1'b0, 2'd1, 3'd1, 6,  P_ZER};
      vt[2] = '{P_ZER, 1'b0, 1'b1, 2'd2, 3'd1, 6,  P_ZER};
      vt[3] = '{P_ZER, 1'b1, 1'b0, 2'd3, 3'd4, 24, P_ZER};
      vt[4] = '{P_SOL, 1'b0, 1'b1, 2'd2, 3'd1, 6,  P_SOL};
      vt[5] = '{P_SOL, 1'b1, 1'b0, 2'd0, 3'd1, 6,  P_SOL ^ 64'h1};

      // reset state
      rst_n = 1'b0; go = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      toggle = 1'b0; contra = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_slots", 64'(slots_used), 64'd0);
      check("rst_dp_valid", 64'(dp_valid_o), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);

      // single-puzzle vectors
      for (int i = 0; i < 6; i++) begin
         do_reset();
         toggle = vt[i].tog; contra = vt[i].con;
         go = 1'b1; in_valid = 1'b1; in_data = vt[i].data;
         #1;
         check($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
         step();
         in_valid = 1'b0;
         check($sformatf("v%0d_slots1", i), 64'(slots_used), 64'd1);
         wait_out(40, lat);
         check($sformatf("v%0d_lat", i), 64'(lat), 64'(vt[i].lat));
         check($sformatf("v%0d_status", i), 64'(out_status), 64'(vt[i].st));
         check($sformatf("v%0d_iters", i), 64'(out_iters), 64'(vt[i].it));
         check($sformatf("v%0d_data", i), out_data, vt[i].od);
         check($sformatf("v%0d_slots0", i), 64'(slots_used), 64'd0);
      end

      // go freeze for 10 cycles mid-flight
      do_reset();
      go = 1'b1; in_valid = 1'b1; in_data = P_ZER;
      step();
      in_valid = 1'b0;
      step(); step();
      go = 1'b0;
      repeat (10) step();
      check("frz_slots", 64'(slots_used), 64'd1);
      check("frz_in_ready", 64'(in_ready), 64'd0);
      check("frz_out_valid", 64'(out_valid), 64'd0);
      go = 1'b1;
      wait_out(40, lat);
      check("frz_lat", 64'(lat + 12), 64'd16);
      check("frz_status", 64'(out_status), 64'd1);
      check("frz_iters", 64'(out_iters), 64'd1);

      // async reset with puzzles in flight and a held output
      do_reset();
      go = 1'b1; in_valid = 1'b1; in_data = P_SOL;
      step();
      for (int k = 0; k < 3; k++) begin
         in_data = pk(k);
         step();
      end
      in_valid = 1'b0;
      repeat (3) step();
      check("mr_out_valid_pre", 64'(out_valid), 64'd1);
      check("mr_slots_pre", 64'(slots_used), 64'd3);
      rst_n = 1'b0;
      #1;
      check("mr_out_valid", 64'(out_valid), 64'd0);
      check("mr_out_data", out_data, 64'd0);
      check("mr_out_iters", 64'(out_iters), 64'd0);
      check("mr_slots", 64'(slots_used), 64'd0);
      check("mr_dp_valid", 64'(dp_valid_o), 64'd0);
      check("mr_dp_data", dp_data_o, 64'd0);
      check("mr_in_ready", 64'(in_ready), 64'd0);
      step();
      rst_n = 1'b1; in_valid = 1'b1; in_data = P_SOL;
      step();
      in_valid = 1'b0;
      wait_out(40, lat);
      check("mr_lat", 64'(lat), 64'd6);
      check("mr_status", 64'(out_status), 64'd0);

      // full ring under backpressure, then drain
      do_reset();
      go = 1'b1; in_valid = 1'b1; in_data = P_SOL;
      step();
      in_valid = 1'b0;
      repeat (5) step();
      in_valid = 1'b1; in_data = pk(0);
      #1;
      check("bp_retire_admit", 64'(in_ready), 64'd1);
      step();
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_slots_swap", 64'(slots_used), 64'd1);
      for (int k = 1; k < 6; k++) begin
         in_data = pk(k);
         step();
      end
      in_valid = 1'b0;
      #1;
      check("bp_slots_full", 64'(slots_used), 64'd6);
      check("bp_in_ready_full", 64'(in_ready), 64'd0);
      mq.delete();
      mon_en = 1'b1;
      repeat (42) step();
      check("bp_held_slots", 64'(slots_used), 64'd6);
      out_ready = 1'b1;
      repeat (8) step();
      mon_en = 1'b0;
      ex[0] = '{P_SOL, 2'd0, 3'd1};
      for (int k = 0; k < 6; k++) ex[k+1] = '{pk(k), 2'd1, 3'd4};
      check("bp_count", 64'(mq.size()), 64'd7);
      for (int i = 0; i < 7 && i < mq.size(); i++) begin
         check($sformatf("bp%0d_data", i), mq[i].data, ex[i].data);
         check($sformatf("bp%0d_status", i), 64'(mq[i].st), 64'(ex[i].st));
         check($sformatf("bp%0d_iters", i), 64'(mq[i].it), 64'(ex[i].it));
      end
      check("bp_slots_end", 64'(slots_used), 64'd0);
      check("bp_out_valid_end", 64'(out_valid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
